// File: rtl/scan_wr_pkg.sv
// -----------------------------------------------------------------------------
// scan_wr_pkg
// Shared definitions for the scanner write packer: FSM state encoding,
// default burst/FIFO/address constants, the flush pad word, and the wrapping
// burst-address helper.
// -----------------------------------------------------------------------------
package scan_wr_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_BURST,
      S_FLUSH,
      S_SYNC
   } state_e;

   localparam int unsigned BURST_LEN_DEF  = 32;
   localparam int unsigned FIFO_DEPTH_DEF = 64;
   localparam int unsigned BASE_ADDR_DEF  = 0;
   localparam int unsigned MAX_ADDR_DEF   = 1843200;   // 307200 * 6
   localparam logic [15:0] PAD_WORD_DEF   = 16'h0000;

   // Next burst start address: advance by one burst, restart at base when the
   // result reaches the exclusive limit.
   function automatic logic [31:0] wrap_add(input logic [31:0] cur,
                                            input logic [31:0] inc,
                                            input logic [31:0] base,
                                            input logic [31:0] lim);
      logic [31:0] s;
      s = cur + inc;
      return (s >= lim) ? base : s;
   endfunction

endpackage

// File: rtl/scan_word_fifo.sv
// -----------------------------------------------------------------------------
// scan_word_fifo
// Single-clock show-ahead word FIFO. The head word is always visible on
// rdata_o; a pop advances to the next entry. Pushes while full and pops while
// empty are ignored here (the caller accounts for drops).
//   clk_i    clock
//   rst_i    synchronous active-high reset (empties the FIFO)
//   push_i   write wdata_i this cycle
//   wdata_i  word to write
//   pop_i    consume the head word this cycle
//   rdata_o  head word (undefined content when empty)
//   level_o  number of stored words
//   full_o   level_o == DEPTH
//   empty_o  level_o == 0
// -----------------------------------------------------------------------------
module scan_word_fifo #(
   parameter  int unsigned DEPTH = 64,
   parameter  int unsigned W     = 16,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned LW    = PW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  wdata_i,
   input  logic          pop_i,
   output logic [W-1:0]  rdata_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic [LW-1:0] level_q;
   logic          do_wr;
   logic          do_rd;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_wr   = push_i && !full_o;
   assign do_rd   = pop_i && !empty_o;
   assign rdata_o = mem_q[rptr_q];
   assign level_o = level_q;

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wptr_q] <= wdata_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_wr) wptr_q <= wptr_q + PW'(1);
         if (do_rd) rptr_q <= rptr_q + PW'(1);
         case ({do_wr, do_rd})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/scan_wr_packer.sv
// -----------------------------------------------------------------------------
// scan_wr_packer
// Packs the scanner byte stream into 16-bit words (first byte low), buffers
// them in a word FIFO and offers fixed-length SDRAM write bursts with a
// wrapping word address. frame_sync flushes the partial burst with pad words
// and restarts the address at BASE_ADDR.
// Optional build macro: SCAN_DROP_CNT_EN adds drop_cnt (saturating count of
// words dropped on a full FIFO).
//   CLK/RESET        clock, synchronous active-high reset
//   byte_in/byte_stb scanner sample and its one-cycle strobe
//   frame_sync       start-of-frame pulse
//   burst_req/addr   burst offer and its start word address
//   burst_ack        controller accepts the offered burst
//   word_pop         controller consumes wr_data this cycle
//   wr_data          FIFO head word, or PAD_WORD once a flush burst runs dry
//   fifo_level       stored words
//   overflow         sticky drop flag
//   busy             high in BURST, FLUSH or SYNC
// -----------------------------------------------------------------------------
module scan_wr_packer
   import scan_wr_pkg::*;
#(
   parameter int unsigned BURST_LEN  = BURST_LEN_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
   parameter int unsigned MAX_ADDR   = MAX_ADDR_DEF,
   parameter logic [15:0] PAD_WORD   = PAD_WORD_DEF,
   parameter int unsigned AW         = 23
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [7:0]    byte_in,
   input  logic          byte_stb,
   input  logic          frame_sync,
   output logic          burst_req,
   output logic [AW-1:0] burst_addr,
   input  logic          burst_ack,
   input  logic          word_pop,
   output logic [15:0]   wr_data,
   output logic [6:0]    fifo_level,
   output logic          overflow,
`ifdef SCAN_DROP_CNT_EN
   output logic [15:0]   drop_cnt,
`endif
   output logic          busy
);

   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CW = $clog2(BURST_LEN) + 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] addr_q;
   logic          sync_pend_q;
   logic          flush_q;
   logic          ovf_q;
   logic [7:0]    half_q;
   logic          half_vld_q;
   logic [15:0]   word_q;
   logic          push_q;

   logic [15:0]   fifo_rdata;
   logic [LW-1:0] fifo_lvl;
   logic          fifo_full;
   logic          fifo_empty;
   logic          burst_done;
   logic          pack_restart;

   scan_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (16)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (push_q),
      .wdata_i (word_q),
      .pop_i   (word_pop),
      .rdata_o (fifo_rdata),
      .level_o (fifo_lvl),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign burst_done = (state_q == S_BURST) && word_pop &&
                       (cnt_q == CW'(BURST_LEN - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK) begin
      if (RESET) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (frame_sync)                     state_d = S_FLUSH;
            else if (fifo_lvl >= LW'(BURST_LEN)) state_d = S_REQ;
         end
         S_REQ:   if (burst_ack) state_d = S_BURST;
         S_BURST: if (burst_done) state_d = (sync_pend_q || flush_q) ? S_SYNC : S_IDLE;
         // A word still in the push register counts as buffered data.
         S_FLUSH: state_d = (fifo_lvl != '0 || push_q) ? S_REQ : S_SYNC;
         S_SYNC:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      burst_req = (state_q == S_REQ);
      busy      = (state_q == S_BURST) || (state_q == S_FLUSH) || (state_q == S_SYNC);
      wr_data   = fifo_rdata;
      if (fifo_empty) wr_data = (state_q == S_BURST) ? PAD_WORD : '0;
   end

   assign burst_addr = addr_q;
   assign fifo_level = 7'(fifo_lvl);
   assign overflow   = ovf_q;

   // ---------------- burst control / address ----------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q       <= '0;
         addr_q      <= AW'(BASE_ADDR);
         sync_pend_q <= 1'b0;
         flush_q     <= 1'b0;
      end else begin
         if (state_q == S_REQ && burst_ack)        cnt_q <= '0;
         else if (state_q == S_BURST && word_pop)  cnt_q <= cnt_q + CW'(1);

         if (burst_done)
            addr_q <= AW'(wrap_add(32'(addr_q), BURST_LEN, BASE_ADDR, MAX_ADDR));
         else if (state_q == S_SYNC)
            addr_q <= AW'(BASE_ADDR);

         // Syncs during an in-flight burst collapse into one pending flag.
         if (state_q == S_SYNC)
            sync_pend_q <= 1'b0;
         else if (frame_sync && (state_q == S_REQ || state_q == S_BURST))
            sync_pend_q <= 1'b1;

         if (state_q == S_FLUSH)     flush_q <= 1'b1;
         else if (state_q == S_SYNC) flush_q <= 1'b0;
      end
   end

   // ---------------- byte packer ----------------
   // Entering FLUSH drops a dangling odd byte; SYNC restarts packing. In both
   // cycles a byte strobed at the same time becomes the new frame's low byte.
   assign pack_restart = (state_q == S_SYNC) || (state_q == S_IDLE && frame_sync);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         half_q     <= '0;
         half_vld_q <= 1'b0;
         word_q     <= '0;
         push_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         push_q <= 1'b0;
         if (pack_restart) begin
            half_vld_q <= byte_stb;
            half_q     <= byte_in;
         end else if (byte_stb) begin
            if (half_vld_q) begin
               word_q     <= {byte_in, half_q};
               push_q     <= 1'b1;
               half_vld_q <= 1'b0;
            end else begin
               half_q     <= byte_in;
               half_vld_q <= 1'b1;
            end
         end
         if (push_q && fifo_full) ovf_q <= 1'b1;
      end
   end

`ifdef SCAN_DROP_CNT_EN
   logic [15:0] drop_q;
   always_ff @(posedge CLK) begin
      if (RESET)                                   drop_q <= '0;
      else if (push_q && fifo_full && drop_q != '1) drop_q <= drop_q + 16'd1;
   end
   assign drop_cnt = drop_q;
`endif

   // Popping an empty FIFO is only legitimate as padding inside a burst.
   always_ff @(posedge CLK) begin
      if (!RESET && word_pop && fifo_empty)
         assert (state_q == S_BURST);
   end

endmodule

// File: tb/tb_scan_wr_packer.sv
// -----------------------------------------------------------------------------
// tb_scan_wr_packer
// Two instances share stimulus: dut_a with default parameters and dut_b with
// MAX_ADDR=64 to exercise the address wrap. Expected FIFO words are queued as
// bytes are strobed and compared as the bench pops them.
// -----------------------------------------------------------------------------
module tb_scan_wr_packer;

   localparam logic [15:0] PAD = 16'h0000;

   logic        CLK = 1'b0;
   logic        RESET, byte_stb, frame_sync, burst_ack, word_pop;
   logic [7:0]  byte_in;

   logic        burst_req_a, overflow_a, busy_a;
   logic [22:0] burst_addr_a;
   logic [15:0] wr_data_a;
   logic [6:0]  fifo_level_a;
   logic        burst_req_b, overflow_b, busy_b;
   logic [22:0] burst_addr_b;
   logic [15:0] wr_data_b;
   logic [6:0]  fifo_level_b;
`ifdef SCAN_DROP_CNT_EN
   logic [15:0] drop_cnt_a, drop_cnt_b;
`endif

   always #5 CLK = ~CLK;

   scan_wr_packer dut_a (
      .CLK(CLK), .RESET(RESET), .byte_in(byte_in), .byte_stb(byte_stb),
      .frame_sync(frame_sync), .burst_req(burst_req_a), .burst_addr(burst_addr_a),
      .burst_ack(burst_ack), .word_pop(word_pop), .wr_data(wr_data_a),
      .fifo_level(fifo_level_a), .overflow(overflow_a),
`ifdef SCAN_DROP_CNT_EN
      .drop_cnt(drop_cnt_a),
`endif
      .busy(busy_a)
   );

   scan_wr_packer #(.MAX_ADDR(64)) dut_b (
      .CLK(CLK), .RESET(RESET), .byte_in(byte_in), .byte_stb(byte_stb),
      .frame_sync(frame_sync), .burst_req(burst_req_b), .burst_addr(burst_addr_b),
      .burst_ack(burst_ack), .word_pop(word_pop), .wr_data(wr_data_b),
      .fifo_level(fifo_level_b), .overflow(overflow_b),
`ifdef SCAN_DROP_CNT_EN
      .drop_cnt(drop_cnt_b),
`endif
      .busy(busy_b)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_q[$];
   logic [7:0]  m_half;
   bit          m_half_v = 1'b0;
   int          m_drops  = 0;
   logic [7:0]  nxt_byte;

   typedef struct {
      int unsigned nbytes;
      logic [6:0]  exp_level;
      logic        exp_req;
   } vec_t;
   vec_t tbl[4];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic strobe(input logic [7:0] b);
      byte_in  = b;
      byte_stb = 1'b1;
      tick();
      byte_stb = 1'b0;
      if (m_half_v) begin
         if (exp_q.size() < 64) exp_q.push_back({b, m_half});
         else m_drops++;
         m_half_v = 1'b0;
      end else begin
         m_half   = b;
         m_half_v = 1'b1;
      end
   endtask

   task automatic strobe_n(input int n);
      for (int i = 0; i < n; i++) begin
         strobe(nxt_byte);
         nxt_byte = nxt_byte + 8'd1;
      end
   endtask

   task automatic wait_req();
      int k;
      k = 0;
      while (!burst_req_a && k < 100) begin
         tick();
         k++;
      end
      check("burst_req_rise", {31'd0, burst_req_a}, 32'd1);
   endtask

   // Accept a burst and pop BURST_LEN words; frame_sync pulses on pops s1/s2.
   task automatic run_burst(input logic [22:0] ea, input logic [22:0] eb,
                            input int s1, input int s2);
      logic [15:0] e;
      check("burst_addr_a", {9'd0, burst_addr_a}, {9'd0, ea});
      check("burst_addr_b", {9'd0, burst_addr_b}, {9'd0, eb});
      burst_ack = 1'b1;
      tick();
      burst_ack = 1'b0;
      for (int i = 0; i < 32; i++) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : PAD;
         check($sformatf("wr_data[%0d]", i), {16'd0, wr_data_a}, {16'd0, e});
         check("busy_in_burst", {31'd0, busy_a}, 32'd1);
         word_pop   = 1'b1;
         frame_sync = (i == s1 || i == s2);
         tick();
         word_pop   = 1'b0;
         frame_sync = 1'b0;
      end
   endtask

   initial begin
      RESET = 1'b1; byte_stb = 1'b0; byte_in = '0; frame_sync = 1'b0;
      burst_ack = 1'b0; word_pop = 1'b0;
      tbl[0] = '{6, 7'd3, 1'b0};
      tbl[1] = '{1, 7'd3, 1'b0};
      tbl[2] = '{1, 7'd4, 1'b0};
      tbl[3] = '{56, 7'd32, 1'b1};
      tick(); tick();
      RESET = 1'b0;

      // Reset state
      check("rst_burst_req", {31'd0, burst_req_a}, 32'd0);
      check("rst_burst_addr", {9'd0, burst_addr_a}, 32'd0);
      check("rst_level", {25'd0, fifo_level_a}, 32'd0);
      check("rst_overflow", {31'd0, overflow_a}, 32'd0);
      check("rst_busy", {31'd0, busy_a}, 32'd0);
      check("rst_wr_data", {16'd0, wr_data_a}, 32'd0);

      // Flush: 11 bytes (odd one discarded) -> 5 data words + 27 pads
      nxt_byte = 8'hA0;
      strobe_n(11);
      tick(); tick(); tick();
      check("flush_pre_level", {25'd0, fifo_level_a}, 32'd5);
      frame_sync = 1'b1; tick(); frame_sync = 1'b0;
      m_half_v = 1'b0;
      wait_req();
      run_burst(23'd0, 23'd0, -1, -1);
      check("flush_sync_busy", {31'd0, busy_a}, 32'd1);
      tick();
      check("flush_end_addr", {9'd0, burst_addr_a}, 32'd0);
      check("flush_end_level", {25'd0, fifo_level_a}, 32'd0);
      check("flush_end_busy", {31'd0, busy_a}, 32'd0);

      // Packing table: 64 bytes 0x00..0x3F in chunks
      nxt_byte = 8'h00;
      for (int i = 0; i < 4; i++) begin
         strobe_n(int'(tbl[i].nbytes));
         tick(); tick(); tick();
         check($sformatf("tbl_level[%0d]", i), {25'd0, fifo_level_a}, {25'd0, tbl[i].exp_level});
         check($sformatf("tbl_req[%0d]", i), {31'd0, burst_req_a}, {31'd0, tbl[i].exp_req});
      end
      check("req_not_busy", {31'd0, busy_a}, 32'd0);
      run_burst(23'd0, 23'd0, -1, -1);
      check("next_addr_a", {9'd0, burst_addr_a}, 32'd32);
      check("post_burst_level", {25'd0, fifo_level_a}, 32'd0);

      // Second burst: dut_b wraps 64 -> 0
      strobe_n(64);
      wait_req();
      run_burst(23'd32, 23'd32, -1, -1);
      check("wrap_addr_b", {9'd0, burst_addr_b}, 32'd0);
      check("nowrap_addr_a", {9'd0, burst_addr_a}, 32'd64);

      // Overflow: 64 words with no ack, then 4 more bytes
      strobe_n(128);
      tick(); tick(); tick();
      check("full_level", {25'd0, fifo_level_a}, 32'd64);
      check("full_no_ovf", {31'd0, overflow_a}, 32'd0);
      strobe_n(4);
      tick(); tick(); tick();
      check("ovf_level", {25'd0, fifo_level_a}, 32'd64);
      check("ovf_flag", {31'd0, overflow_a}, 32'd1);
      check("ovf_model_drops", m_drops, 32'd2);
`ifdef SCAN_DROP_CNT_EN
      check("drop_cnt", {16'd0, drop_cnt_a}, 32'd2);
`endif
      wait_req();
      run_burst(23'd64, 23'd0, -1, -1);

      // Sync mid-burst (two syncs collapse): completes at original address
      wait_req();
      run_burst(23'd96, 23'd32, 9, 19);
      check("midsync_sync_busy", {31'd0, busy_a}, 32'd1);
      tick();
      check("midsync_addr_a", {9'd0, burst_addr_a}, 32'd0);
      check("midsync_addr_b", {9'd0, burst_addr_b}, 32'd0);
      check("midsync_level", {25'd0, fifo_level_a}, 32'd0);
      repeat (5) tick();
      check("no_second_flush_req", {31'd0, burst_req_a}, 32'd0);
      check("no_second_flush_busy", {31'd0, busy_a}, 32'd0);

      // Reset mid-burst
      strobe_n(64);
      wait_req();
      run_burst(23'd0, 23'd0, -1, -1);
      strobe_n(64);
      wait_req();
      check("prerst_addr", {9'd0, burst_addr_a}, 32'd32);
      check("prerst_ovf", {31'd0, overflow_a}, 32'd1);
      burst_ack = 1'b1; tick(); burst_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rst_burst_wr_data[%0d]", i), {16'd0, wr_data_a}, {16'd0, exp_q.pop_front()});
         word_pop = 1'b1; tick(); word_pop = 1'b0;
      end
      word_pop = 1'b1; RESET = 1'b1;
      tick();
      word_pop = 1'b0; RESET = 1'b0;
      exp_q.delete(); m_half_v = 1'b0;
      check("midrst_req", {31'd0, burst_req_a}, 32'd0);
      check("midrst_level", {25'd0, fifo_level_a}, 32'd0);
      check("midrst_addr", {9'd0, burst_addr_a}, 32'd0);
      check("midrst_ovf", {31'd0, overflow_a}, 32'd0);
      check("midrst_busy", {31'd0, busy_a}, 32'd0);
`ifdef SCAN_DROP_CNT_EN
      check("midrst_drop_cnt", {16'd0, drop_cnt_a}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
